image_crop_stream: RTL and testbench

- Streaming crop stage directly upstream of the hls4ml `myproject` core.
- Consumes a full IN_ROWSxIN_COLS raster-order pixel stream and forwards only the OUT_ROWSxOUT_COLS window whose top-left corner is (crop_y, crop_x).
- Its output drives `conv2d_input_V_data_0_V_*`.
- Pixels outside the window are accepted and discarded, so upstream frame alignment is preserved.

---
 rtl/crop_pkg.sv | 24 ++
 rtl/crop_out_reg.sv | 30 +++
 rtl/image_crop_stream.sv | 130 +++++++++++++
 tb/tb_image_crop_stream.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crop_pkg.sv
// Shared defaults, types and FSM encoding for the streaming crop stage.
package crop_pkg;

    localparam int DFLT_DATA_W   = 16;
    localparam int DFLT_IN_ROWS  = 100;
    localparam int DFLT_IN_COLS  = 160;
    localparam int DFLT_OUT_ROWS = 48;
    localparam int DFLT_OUT_COLS = 48;

    localparam int DFLT_ROW_W = $clog2(DFLT_IN_ROWS);
    localparam int DFLT_COL_W = $clog2(DFLT_IN_COLS);
    localparam int OUT_PIX    = DFLT_OUT_ROWS * DFLT_OUT_COLS;
    localparam int CNT_W      = $clog2(OUT_PIX + 1);

    typedef logic [DFLT_DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } crop_state_t;

endpackage

// File: rtl/crop_out_reg.sv
// One-deep valid/ready output register; a load may coincide with a pop.
module crop_out_reg
    import crop_pkg::*;
#(
    parameter int DATA_W = DFLT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    // Upstream only loads when the slot is empty or being popped, so a load
    // never overwrites an unaccepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/image_crop_stream.sv
// Streaming crop: forwards the OUT_ROWSxOUT_COLS window of a raster frame,
// accepting and dropping every pixel outside it.
module image_crop_stream
    import crop_pkg::*;
#(
    parameter int DATA_W   = DFLT_DATA_W,
    parameter int IN_ROWS  = DFLT_IN_ROWS,
    parameter int IN_COLS  = DFLT_IN_COLS,
    parameter int OUT_ROWS = DFLT_OUT_ROWS,
    parameter int OUT_COLS = DFLT_OUT_COLS,
    parameter int ROW_W    = $clog2(IN_ROWS),
    parameter int COL_W    = $clog2(IN_COLS)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [ROW_W-1:0]  crop_y,
    input  logic [COL_W-1:0]  crop_x,
    input  logic [DATA_W-1:0] img_in_TDATA,
    input  logic              img_in_TVALID,
    output logic              img_in_TREADY,
    output logic [DATA_W-1:0] crop_out_TDATA,
    output logic              crop_out_TVALID,
    input  logic              crop_out_TREADY
);

    localparam int WIN_CNT_W = $clog2(OUT_ROWS * OUT_COLS + 1);

    localparam logic [ROW_W-1:0] Y_MAX    = ROW_W'(IN_ROWS - OUT_ROWS);
    localparam logic [COL_W-1:0] X_MAX    = COL_W'(IN_COLS - OUT_COLS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IN_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_COLS - 1);
    localparam logic [ROW_W:0]   WIN_ROWS = (ROW_W+1)'(OUT_ROWS);
    localparam logic [COL_W:0]   WIN_COLS = (COL_W+1)'(OUT_COLS);

    crop_state_t state, next_state;

    logic [ROW_W-1:0]     y0, in_row;
    logic [COL_W-1:0]     x0, in_col;
    logic [WIN_CNT_W-1:0] out_cnt;
    logic                 start, in_xfer, in_win, last_pix, load;
    logic                 row_in, col_in;

    assign start         = (state == IDLE) && ap_start;
    assign img_in_TREADY = (state == RUN) && (!crop_out_TVALID || crop_out_TREADY);
    assign in_xfer       = img_in_TVALID && img_in_TREADY;

    // One extra bit keeps origin + window size from wrapping.
    assign row_in = ({1'b0, in_row} >= {1'b0, y0}) &&
                    ({1'b0, in_row} <  ({1'b0, y0} + WIN_ROWS));
    assign col_in = ({1'b0, in_col} >= {1'b0, x0}) &&
                    ({1'b0, in_col} <  ({1'b0, x0} + WIN_COLS));
    assign in_win   = row_in && col_in;
    assign last_pix = (in_row == LAST_ROW) && (in_col == LAST_COL);
    assign load     = in_xfer && in_win;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ap_done    = 1'b0;
        ap_ready   = 1'b0;
        ap_idle    = 1'b0;
        unique case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) next_state = RUN;
            end
            RUN: begin
                if (in_xfer && last_pix) next_state = DRAIN;
            end
            DRAIN: begin
                // Leave as soon as the final beat is gone or leaving now.
                if (!crop_out_TVALID || crop_out_TREADY) next_state = DONE;
            end
            DONE: begin
                ap_done    = 1'b1;
                ap_ready   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            y0      <= '0;
            x0      <= '0;
            in_row  <= '0;
            in_col  <= '0;
            out_cnt <= '0;
        end else if (start) begin
            y0      <= (crop_y > Y_MAX) ? Y_MAX : crop_y;
            x0      <= (crop_x > X_MAX) ? X_MAX : crop_x;
            in_row  <= '0;
            in_col  <= '0;
            out_cnt <= '0;
        end else if (in_xfer) begin
            if (in_col == LAST_COL) begin
                in_col <= '0;
                in_row <= in_row + 1'b1;
            end else begin
                in_col <= in_col + 1'b1;
            end
            if (in_win) out_cnt <= out_cnt + 1'b1;
        end
    end

    crop_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .load      (load),
        .load_data (img_in_TDATA),
        .out_data  (crop_out_TDATA),
        .out_valid (crop_out_TVALID),
        .out_ready (crop_out_TREADY)
    );

endmodule

// File: tb/tb_image_crop_stream.sv
// Randomised bench for image_crop_stream against a raster-window reference model.
module tb_image_crop_stream;
    import crop_pkg::*;

    localparam int FRAME_PIX = DFLT_IN_ROWS * DFLT_IN_COLS;

    logic                   ap_clk = 1'b0;
    logic                   ap_rst_n;
    logic                   ap_start;
    logic                   ap_done, ap_idle, ap_ready;
    logic [DFLT_ROW_W-1:0]  crop_y;
    logic [DFLT_COL_W-1:0]  crop_x;
    pixel_t                 img_in_TDATA;
    logic                   img_in_TVALID, img_in_TREADY;
    pixel_t                 crop_out_TDATA;
    logic                   crop_out_TVALID, crop_out_TREADY;

    image_crop_stream #(
        .DATA_W   (DFLT_DATA_W),
        .IN_ROWS  (DFLT_IN_ROWS),
        .IN_COLS  (DFLT_IN_COLS),
        .OUT_ROWS (DFLT_OUT_ROWS),
        .OUT_COLS (DFLT_OUT_COLS)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .ap_idle         (ap_idle),
        .ap_ready        (ap_ready),
        .crop_y          (crop_y),
        .crop_x          (crop_x),
        .img_in_TDATA    (img_in_TDATA),
        .img_in_TVALID   (img_in_TVALID),
        .img_in_TREADY   (img_in_TREADY),
        .crop_out_TDATA  (crop_out_TDATA),
        .crop_out_TVALID (crop_out_TVALID),
        .crop_out_TREADY (crop_out_TREADY)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int failures = 0;

    int exp_q[$];
    int got[OUT_PIX];

    // Owned by the compare process.
    int  out_total = 0, done_total = 0, in_total = 0;
    int  cyc = 0, last_out_cyc = 0, done_cyc = 0, last_val = -1;
    bit  prev_stall = 1'b0;
    int  prev_data = 0;

    // Owned by the stimulus process.
    bit  chk_en = 1'b0, busy = 1'b0, stall_active = 1'b0;
    int  out_base = 0, done_base = 0, in_base = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void build_expected(input int cy, input int cx);
        int y0, x0, r, c;
        y0 = (cy > DFLT_IN_ROWS - DFLT_OUT_ROWS) ? DFLT_IN_ROWS - DFLT_OUT_ROWS : cy;
        x0 = (cx > DFLT_IN_COLS - DFLT_OUT_COLS) ? DFLT_IN_COLS - DFLT_OUT_COLS : cx;
        exp_q.delete();
        for (int i = 0; i < FRAME_PIX; i++) begin
            r = i / DFLT_IN_COLS;
            c = i % DFLT_IN_COLS;
            if (r >= y0 && r < y0 + DFLT_OUT_ROWS && c >= x0 && c < x0 + DFLT_OUT_COLS)
                exp_q.push_back(i);
        end
    endfunction

    always @(negedge ap_clk) begin
        int k;
        cyc++;
        if (chk_en) begin
            if (prev_stall) begin
                check("hold_valid", int'(crop_out_TVALID), 1);
                check("hold_data", int'(crop_out_TDATA), prev_data);
            end
            if (crop_out_TVALID && crop_out_TREADY) begin
                k = out_total - out_base;
                if (k < exp_q.size()) check("out_data", int'(crop_out_TDATA), exp_q[k]);
                else                  check("out_extra", k, exp_q.size() - 1);
                if (k < OUT_PIX) got[k] = int'(crop_out_TDATA);
                last_val     = int'(crop_out_TDATA);
                last_out_cyc = cyc;
                out_total++;
            end
            if (img_in_TVALID && img_in_TREADY) in_total++;
            if (stall_active) check("stall_in_ready", int'(img_in_TREADY), 0);
            if (busy && done_total == done_base) begin
                check("busy_idle", int'(ap_idle), 0);
            end else begin
                check("idle_valid", int'(crop_out_TVALID), 0);
            end
            if (ap_done) begin
                check("done_ready", int'(ap_ready), 1);
                check("count_at_done", out_total - out_base, OUT_PIX);
                done_cyc = cyc;
                done_total++;
            end
            prev_stall = crop_out_TVALID && !crop_out_TREADY;
            prev_data  = int'(crop_out_TDATA);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run_frame(input int cy, input int cx, input int vpct, input int rpct,
                             input int stall_at, input int abort_at);
        int  idx;
        int  stall_left;
        bit  stalled;
        idx        = 0;
        stall_left = 0;
        stalled    = 1'b0;
        build_expected(cy, cx);
        @(posedge ap_clk); #1;
        out_base  = out_total;
        done_base = done_total;
        in_base   = in_total;
        crop_y    = DFLT_ROW_W'(cy);
        crop_x    = DFLT_COL_W'(cx);
        ap_start  = 1'b1;
        img_in_TVALID   = 1'b0;
        crop_out_TREADY = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        busy     = 1'b1;
        for (int n = 0; n < 60000; n++) begin
            if (stall_at >= 0 && !stalled && (out_total - out_base) == stall_at && crop_out_TVALID) begin
                stall_left = 200;
                stalled    = 1'b1;
            end
            stall_active    = (stall_left > 0);
            ap_start        = (idx == 3000);
            img_in_TVALID   = (idx < FRAME_PIX) && ($urandom_range(99) < vpct);
            img_in_TDATA    = DFLT_DATA_W'(idx);
            crop_out_TREADY = stall_active ? 1'b0 : ($urandom_range(99) < rpct);
            @(negedge ap_clk);
            if (img_in_TVALID && img_in_TREADY) idx++;
            if (done_total != done_base) break;
            if (abort_at >= 0 && idx >= abort_at) break;
            @(posedge ap_clk); #1;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) check("stall_beat_held", out_total - out_base, stall_at);
            end
        end
        stall_active    = 1'b0;
        ap_start        = 1'b0;
        if (abort_at < 0) begin
            img_in_TVALID   = 1'b0;
            crop_out_TREADY = 1'b1;
            repeat (3) @(negedge ap_clk);
            busy = 1'b0;
            check("done_pulses", done_total - done_base, 1);
            check("out_count", out_total - out_base, OUT_PIX);
            check("in_beats", in_total - in_base, FRAME_PIX);
            check("idle_after", int'(ap_idle), 1);
            check("done_after_last_out", int'(done_cyc > last_out_cyc), 1);
        end
    endtask

    initial begin
        ap_rst_n        = 1'b1;
        ap_start        = 1'b0;
        crop_y          = '0;
        crop_x          = '0;
        img_in_TVALID   = 1'b0;
        img_in_TDATA    = '0;
        crop_out_TREADY = 1'b0;
        #3 ap_rst_n = 1'b0;
        #1;
        check("rst_valid", int'(crop_out_TVALID), 0);
        check("rst_data", int'(crop_out_TDATA), 0);
        check("rst_idle", int'(ap_idle), 1);
        check("rst_done", int'(ap_done), 0);
        check("rst_ready", int'(ap_ready), 0);
        check("rst_in_ready", int'(img_in_TREADY), 0);
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        chk_en = 1'b1;

        // Window at (10,10), full rate.
        build_expected(10, 10);
        check("model_size", exp_q.size(), 2304);
        check("model_first", exp_q[0], 1610);
        check("model_last", exp_q[exp_q.size() - 1], 9177);
        run_frame(10, 10, 100, 100, -1, -1);
        check("a_first", got[0], 1610);
        check("a_last", last_val, 9177);

        // Same window, random 50% valid / ready.
        run_frame(10, 10, 50, 50, -1, -1);
        check("b_first", got[0], 1610);
        check("b_last", last_val, 9177);

        // Clamped origin (52,112) plus a 200-cycle stall at output beat 100.
        build_expected(99, 200);
        check("model_clamp_first", exp_q[0], 8432);
        check("model_clamp_last", exp_q[exp_q.size() - 1], 15999);
        run_frame(99, 200, 100, 100, 100, -1);
        check("c_first", got[0], 8432);
        check("c_beat100", got[100], 52 * 160 + 112 + 100 - 96 + 160 * 2);
        check("c_last", last_val, 15999);
        check("c_done_latency", done_cyc - last_out_cyc, 1);

        // Abort mid-frame with an asynchronous reset.
        run_frame(0, 0, 100, 100, -1, 5000);
        chk_en = 1'b0;
        busy   = 1'b0;
        #2 ap_rst_n = 1'b0;
        #1;
        check("abort_valid", int'(crop_out_TVALID), 0);
        check("abort_idle", int'(ap_idle), 1);
        check("abort_in_ready", int'(img_in_TREADY), 0);
        img_in_TVALID = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        chk_en = 1'b1;

        // Fresh frame at origin (0,0) after the abort.
        build_expected(0, 0);
        check("model_origin_48", exp_q[48], 160);
        run_frame(0, 0, 100, 100, -1, -1);
        check("e_first", got[0], 0);
        check("e_row_wrap", got[48], 160);
        check("e_last", last_val, 47 * 160 + 47);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
